// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: command, MTHI/MTLO and result bundle between the EXE stage
// and the iterative multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, Op1, Op2, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, Op1, Op2, flush, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One bit per cycle: shift-add multiply on magnitudes, restoring divide with a
// 33-bit partial remainder, sign fix-up in FIX.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- multiply leaves RUN once the
// remaining multiplier magnitude bits are all zero; FIX realigns the product.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CW = 6;
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_q;
  logic             neg_r;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic             is_div;
  logic             is_sgn;
  logic             b_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [PW-1:0]    prod_al;
  logic [PW-1:0]    mul_res;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  // Operand classification and magnitudes of the latched operands
  assign is_div = op_r[1];
  assign is_sgn = ~op_r[0];
  assign b_zero = (b_r == '0);
  assign abs_a  = (is_sgn && a_r[WIDTH-1]) ? WIDTH'(-a_r) : a_r;
  assign abs_b  = (is_sgn && b_r[WIDTH-1]) ? WIDTH'(-b_r) : b_r;

  // One multiply step: add multiplicand into the upper half when the multiplier LSB is set
  assign add_sum = {1'b0, prod[PW-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : {WIDTH{1'b0}})};

  // One restoring-divide step: shift in the next dividend bit and trial-subtract
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign rem_ge = (rem_sh >= {1'b0, mag_b});

`ifdef MULDIV_EARLY_OUT_EN
  // An early exit leaves the partial product cnt positions too high
  assign prod_al = prod >> cnt;
`else
  assign prod_al = prod;
`endif

  // Sign correction applied when committing in FIX
  assign mul_res = neg_q ? PW'(-prod_al) : prod_al;
  assign q_res   = neg_q ? WIDTH'(-quo) : quo;
  assign r_res   = neg_r ? WIDTH'(-rem) : rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = PREP;
      PREP: begin
        if (is_div && b_zero) state_nxt = FIX;
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && b_zero) state_nxt = FIX;
`endif
        else state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CW'(1)) state_nxt = FIX;
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && (mag_b[WIDTH-1:1] == '0)) state_nxt = FIX;
`endif
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Datapath, HI/LO and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      mag_a        <= '0;
      mag_b        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      prod         <= '0;
      rem          <= '0;
      quo          <= '0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
    end else begin
      bus.busy     <= (state_nxt != IDLE);
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_hi) bus.hi <= bus.wr_data;
          if (bus.wr_lo) bus.lo <= bus.wr_data;
          if (bus.start) begin
            op_r <= bus.op;
            a_r  <= bus.Op1;
            b_r  <= bus.Op2;
          end
        end
        PREP: begin
          mag_a <= abs_a;
          mag_b <= abs_b;
          neg_q <= is_sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r <= is_sgn & a_r[WIDTH-1];
          prod  <= '0;
          rem   <= '0;
          quo   <= abs_a;
          cnt   <= ITERS;
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            rem <= rem_ge ? WIDTH'(rem_sh - {1'b0, mag_b}) : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], rem_ge};
          end else begin
            prod  <= {add_sum, prod[WIDTH-1:1]};
            mag_b <= mag_b >> 1;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            bus.done <= 1'b1;
            if (is_div && b_zero) begin
              bus.div_zero <= 1'b1;
              bus.lo       <= '1;
              bus.hi       <= a_r;
            end else if (is_div) begin
              bus.lo <= q_res;
              bus.hi <= r_res;
            end else begin
              bus.hi <= mul_res[PW-1:WIDTH];
              bus.lo <= mul_res[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table vectors, hand-written corner sequences and random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected cycles from the start-sampling cycle to the done cycle
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    if (op[1] && b == 32'd0) return 3;
    m = (!op[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      if (m == 32'd0) return 3;
      for (int i = 31; i >= 0; i--) if (m[i]) return 3 + i + 1;
    end
`endif
    if (m == 32'd0) return 35;
    return 35;
  endfunction

  // Reference: 64-bit arithmetic with SV truncating division semantics
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; lo = 32'hFFFFFFFF; hi = a;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  // Launch at a negedge (start sampled on the next posedge) and wait for done
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic whi, input logic [31:0] wd,
                        output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz,
                        output int lat, output logic busy1, output logic [31:0] hi1);
    bus.op = op; bus.Op1 = a; bus.Op2 = b; bus.start = 1'b1;
    bus.wr_hi = whi; bus.wr_data = wd;
    lat = -1; rhi = '0; rlo = '0; rdz = 1'b0; busy1 = 1'b0; hi1 = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        busy1 = bus.busy; hi1 = bus.hi;
      end
      if (bus.done) begin
        lat = k; rhi = bus.hi; rlo = bus.lo; rdz = bus.div_zero;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] rhi, rlo, hi1, ehi, elo, lo_b, hi_b;
    logic        rdz, edz, busy1;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          lat;

    vecs[0]  = '{2'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{2'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[8]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'd1, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0};
    vecs[10] = '{2'd2, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{2'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.Op1 = '0; bus.Op2 = '0; bus.flush = 1'b0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dz", 64'(bus.div_zero), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'd0, rhi, rlo, rdz, lat, busy1, hi1);
      chk($sformatf("vec%0d_hi", i), 64'(rhi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rlo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dz", i), 64'(rdz), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      chk($sformatf("vec%0d_busy", i), 64'(busy1), 64'd1);
    end

    // MTHI while idle lands on the next edge
    bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    chk("mthi_idle", 64'(bus.hi), 64'hA5A5A5A5);

    // MTLO and a second start while busy are both ignored
    lo_b = bus.lo;
    bus.op = 2'd1; bus.Op1 = 32'd5; bus.Op2 = 32'd3; bus.start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin
        bus.wr_lo = 1'b1; bus.wr_data = 32'd1;
        bus.start = 1'b1; bus.op = 2'd3; bus.Op1 = 32'd100; bus.Op2 = 32'd7;
      end
      if (k == 3) begin
        bus.wr_lo = 1'b0; bus.start = 1'b0;
        chk("mtlo_busy", 64'(bus.lo), 64'(lo_b));
      end
      if (bus.done) begin lat = k; break; end
    end
    chk("busy_start_lat", 64'(lat), 64'(exp_lat(2'd1, 32'd3)));
    chk("busy_start_hi", 64'(bus.hi), 64'd0);
    chk("busy_start_lo", 64'(bus.lo), 64'd15);
    @(negedge clk);
    chk("no_queue_busy", 64'(bus.busy), 64'd0);

    // Start with MTHI: the write lands, then the result overwrites it
    run_op(2'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 32'hDEADBEEF, rhi, rlo, rdz, lat, busy1, hi1);
    chk("start_wr_hi_early", 64'(hi1), 64'hDEADBEEF);
    chk("start_wr_hi_final", 64'(rhi), 64'hFFFFFFFF);
    chk("start_wr_lo_final", 64'(rlo), 64'hFFFFFFFA);

    // Flush at N+10, restart at N+11, completion at N+46
    hi_b = bus.hi; lo_b = bus.lo;
    bus.op = 2'd0; bus.Op1 = 32'd7; bus.Op2 = 32'h80000001; bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      chk($sformatf("flush_nodone_%0d", k), 64'(bus.done), 64'd0);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'(hi_b));
    chk("flush_lo", 64'(bus.lo), 64'(lo_b));
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 32'd0, rhi, rlo, rdz, lat, busy1, hi1);
    chk("after_flush_lat", 64'(lat), 64'd35);
    chk("after_flush_hi", 64'(rhi), 64'd2);
    chk("after_flush_lo", 64'(rlo), 64'd14);

    // Reset mid-operation aborts and clears HI/LO
    bus.op = 2'd1; bus.Op1 = 32'd5; bus.Op2 = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_hi", 64'(bus.hi), 64'd0);
    chk("rst_mid_lo", 64'(bus.lo), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.done) chk("rst_mid_spurious_done", 64'(bus.done), 64'd0);
    end

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      ref_model(rop, ra, rb, ehi, elo, edz);
      run_op(rop, ra, rb, 1'b0, 32'd0, rhi, rlo, rdz, lat, busy1, hi1);
      chk($sformatf("rnd%0d_op%0d_hi", i, rop), 64'(rhi), 64'(ehi));
      chk($sformatf("rnd%0d_op%0d_lo", i, rop), 64'(rlo), 64'(elo));
      chk($sformatf("rnd%0d_op%0d_dz", i, rop), 64'(rdz), 64'(edz));
      chk($sformatf("rnd%0d_op%0d_lat", i, rop), 64'(lat), 64'(exp_lat(rop, rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO register pair for the EXE stage. It takes the multi-cycle MULT/MULTU/DIV/DIVU work off the single-cycle ALU path. It computes one bit per cycle from a registered FSM and holds `busy` high so the hazard unit stalls any dependent MFHI/MFLO. MTHI/MTLO writes and pipeline flush also land here.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported; HI and LO are each `WIDTH` bits.
- `clk` in 1: the only clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: launches an operation; sampled only in IDLE.
- `op` in 2: 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `Op1` in 32: rs; the dividend for divide operations.
- `Op2` in 32: rt; the divisor for divide operations.
- `flush` in 1: aborts any in-flight operation.
- `wr_hi` in 1: MTHI write enable.
- `wr_lo` in 1: MTLO write enable.
- `wr_data` in 32: data for MTHI/MTLO.
- `busy` out 1: high while in PREP, RUN or FIX.
- `done` out 1: one-cycle pulse when the result is committed.
- `div_zero` out 1: qualifies `done`; high when the operation was a divide by zero.
- `hi` out 32: registered HI.
- `lo` out 32: registered LO.

## Operation
- FSM states are IDLE, PREP, RUN and FIX.
- IDLE → PREP on `start`. `op`, `Op1` and `Op2` are latched into internal registers.
- PREP:
  - For signed ops, latch operand magnitudes and the result signs. Quotient sign is Op1[31]^Op2[31]; remainder sign is Op1[31].
  - For divide with a zero divisor, go to FIX. Otherwise load the 6-bit iteration counter with 32 and go to RUN.
- RUN:
  - Multiply is shift-add on magnitudes, one multiplier bit per cycle, into a 64-bit product.
  - Divide is restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
  - The counter decrements each cycle; RUN → FIX when it reaches 0.
- FIX: apply two's-complement sign correction, write HI/LO, return to IDLE.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero: lo = 32'hFFFFFFFF, hi = Op1, `div_zero` = 1.
- DIV of 32'h80000000 by 32'hFFFFFFFF: lo = 32'h80000000, hi = 0, `div_zero` = 0.
- `start` while busy is ignored; there is no queueing.
- `wr_hi`/`wr_lo`:
  - Applied at the next edge when in IDLE.
  - Ignored while busy.
  - When asserted together with `start`, the write is applied, the operation starts, and the result later overwrites it.
- `flush` in any state:
  - Next state is IDLE; no `done`.
  - HI/LO keep their pre-operation values.
  - `flush` has priority over `start` in the same cycle.
- `rst` has priority over everything.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `div_zero` = 0, `hi` = 0, `lo` = 0.
- Reset mid-operation behaves as a flush, and additionally clears HI/LO.
- Let cycle N be the cycle in which `start` is sampled in IDLE.
- Normal operation:
  - PREP is cycle N+1, RUN is N+2..N+33, FIX is N+34.
  - `busy` is high from N+1 through N+34.
  - `hi`, `lo`, `done` and `div_zero` become valid at N+35; `done` is high for that cycle only.
- Divide by zero: PREP at N+1, FIX at N+2, `done` at N+3.
- A new `start` is accepted in the `done` cycle, since the FSM is then in IDLE, so operations can run back-to-back.
- `done` and `div_zero` are registered outputs.
- `hi` and `lo` change only at reset, on an MTHI/MTLO write, or on the edge ending FIX.

## Configuration
- Macro: `MULDIV_EARLY_OUT_EN`.
- Defined: a multiply exits RUN as soon as the remaining unconsumed multiplier magnitude bits are all zero. FIX aligns the product by the remaining count.
  - Latency becomes N + 3 + (index of the highest set bit of |Op2| + 1).
  - If |Op2| = 0, RUN is skipped and `done` is at N+3.
  - Divide latency is unchanged.
- Undefined: every non-div-by-zero operation uses exactly 32 RUN cycles, giving fixed latency N+35.

## Test plan
- MULT Op1 = 32'hFFFFFFFE (−2), Op2 = 32'h00000003 → at N+35: hi = 32'hFFFFFFFF, lo = 32'hFFFFFFFA, `done` = 1, `div_zero` = 0. Repeat with MULTU on the same operands → hi = 32'h00000002, lo = 32'hFFFFFFFA.
- DIV Op1 = −7, Op2 = 2 → lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF. DIVU Op1 = 100, Op2 = 7 → lo = 14, hi = 2.
- DIVU Op1 = 32'h12345678, Op2 = 0 → `done` at N+3, `div_zero` = 1, lo = 32'hFFFFFFFF, hi = 32'h12345678.
- Launch a MULT, assert `flush` at N+10 → `busy` = 0 at N+11, no `done` pulse, hi/lo unchanged. A second `start` at N+11 completes normally at N+46.
- MTHI 32'hA5A5A5A5 while idle → hi updated next cycle. MTLO 32'h1 while busy → lo unchanged. `start` together with `wr_hi` → write lands, then the result overwrites it at completion.
- With `MULDIV_EARLY_OUT_EN`: MULTU Op1 = 5, Op2 = 3 → `done` at N+5, lo = 15, hi = 0. Without the macro → `done` at N+35 with the same values.
